// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state sequencer feeding the accumulator ALU over the shared bus
module alu_sequencer #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    output logic                  rf_oe,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [4:0]            alu_op,
    output logic                  alu_wr,
    output logic                  alu_rd,
    inout  wire  [XLEN-1:0]       bus,
    output logic                  done,
    output logic                  branch_taken,
    output logic                  illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_LOADB, S_EXEC, S_WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        done_q, done_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;
    logic        imm_oe;
    logic        legal;

    // Legality is judged on the offered word so a rejected opcode never disturbs ir.
    always_comb begin
        legal = 1'b0;
        case (instr[6:0])
            OPC_OP:
                legal = (instr[31:25] == 7'b0000000) ||
                        ((instr[31:25] == 7'b0100000) &&
                         ((instr[14:12] == 3'b000) || (instr[14:12] == 3'b101)));
            OPC_OP_IMM:
                if (instr[14:12] == 3'b001)
                    legal = (instr[31:25] == 7'b0000000);
                else if (instr[14:12] == 3'b101)
                    legal = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
                else
                    legal = 1'b1;
            OPC_BRANCH:
                legal = (instr[14:13] != 2'b01);
            default:
                legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        done_d      = 1'b0;
        taken_d     = taken_q;
        illegal_d   = 1'b0;
        instr_ready = 1'b0;
        rf_raddr    = '0;
        rf_oe       = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        alu_op      = 5'b00000;
        alu_wr      = 1'b0;
        alu_rd      = 1'b0;
        imm_oe      = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (legal) begin
                        ir_d    = instr;
                        state_d = S_LOADB;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_LOADB: begin
                alu_wr = 1'b1;
                if (ir_q[6:0] == OPC_OP_IMM) begin
                    imm_oe = 1'b1;
                end else begin
                    rf_raddr = ir_q[24:20];
                    rf_oe    = 1'b1;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_raddr = ir_q[19:15];
                rf_oe    = 1'b1;
                alu_wr   = 1'b1;
                case (ir_q[6:0])
                    OPC_OP:     alu_op = {1'b1, ir_q[30], ir_q[14:12]};
                    // Only the right shifts take ir[30]; ADDI with a negative immediate stays ADD.
                    OPC_OP_IMM: alu_op = (ir_q[14:12] == 3'b101) ? {1'b1, ir_q[30], 3'b101}
                                                                 : {2'b10, ir_q[14:12]};
                    default:    alu_op = {2'b01, ir_q[14:12]};
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                alu_rd = 1'b1;
                if (ir_q[6:0] == OPC_BRANCH) begin
                    taken_d = bus[0];
                end else begin
                    rf_we    = (ir_q[11:7] != 5'd0);
                    rf_waddr = ir_q[11:7];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus          = imm_oe ? {{(XLEN-12){ir_q[31]}}, ir_q[31:20]} : {XLEN{1'bz}};
    assign done         = done_q;
    assign branch_taken = taken_q;
    assign illegal      = illegal_q;

    logic bus_unused;
    assign bus_unused = ^bus[XLEN-1:1];

endmodule
